exe_stage_md: RTL

Parametrised execute stage with an in-stage iterative divider, sized stores and a flush path. It sits between the decode stage and the memory stage and keeps the existing valid/allowin pipeline handshake. Non-divide operations go through the existing combinational `alu` in one cycle. Divide and modulo operations hold the stage for a fixed, width-dependent number of cycles. Loads and stores drive the data SRAM with byte enables and a misalignment flag.

---
 rtl/exe_stage_md.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/exe_stage_md.sv
// Execute stage: one-cycle ALU path, in-stage restoring divider, sized
// store byte enables with misalignment detection, and a flush path.

// Combinational ALU, one-hot op select.
// op: 0 add, 1 sub, 2 slt, 3 sltu, 4 and, 5 nor, 6 or, 7 xor,
//     8 sll, 9 srl, 10 sra, 11 lui (passes src2 through).
module alu #(
  parameter int DATA_W = 32
) (
  input  logic [11:0]       alu_op,
  input  logic [DATA_W-1:0] alu_src1,
  input  logic [DATA_W-1:0] alu_src2,
  output logic [DATA_W-1:0] alu_result
);
  localparam int SH_W = $clog2(DATA_W);

  logic [SH_W-1:0] sh;
  assign sh = alu_src2[SH_W-1:0];

  // AND-OR mux over the one-hot op vector
  always_comb begin
    alu_result = ({DATA_W{alu_op[0]}}  & (alu_src1 + alu_src2))
               | ({DATA_W{alu_op[1]}}  & (alu_src1 - alu_src2))
               | ({DATA_W{alu_op[2]}}  & DATA_W'($signed(alu_src1) < $signed(alu_src2)))
               | ({DATA_W{alu_op[3]}}  & DATA_W'(alu_src1 < alu_src2))
               | ({DATA_W{alu_op[4]}}  & (alu_src1 & alu_src2))
               | ({DATA_W{alu_op[5]}}  & ~(alu_src1 | alu_src2))
               | ({DATA_W{alu_op[6]}}  & (alu_src1 | alu_src2))
               | ({DATA_W{alu_op[7]}}  & (alu_src1 ^ alu_src2))
               | ({DATA_W{alu_op[8]}}  & (alu_src1 << sh))
               | ({DATA_W{alu_op[9]}}  & (alu_src1 >> sh))
               | ({DATA_W{alu_op[10]}} & $unsigned($signed(alu_src1) >>> sh))
               | ({DATA_W{alu_op[11]}} & alu_src2);
  end
endmodule

module exe_stage_md #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  output logic                 ex_allowin,
  input  logic                 id_to_ex_valid,
  input  logic [11:0]          id_alu_op,
  input  logic [DATA_W-1:0]    id_src1,
  input  logic [DATA_W-1:0]    id_src2,
  input  logic [2:0]           id_div_op,
  input  logic                 id_mem_re,
  input  logic                 id_mem_wr,
  input  logic [1:0]           id_mem_size,
  input  logic [DATA_W-1:0]    id_st_data,
  input  logic                 id_rf_we,
  input  logic [4:0]           id_rf_waddr,
  input  logic [31:0]          id_pc,
  input  logic                 mem_allowin,
  output logic                 ex_to_mem_valid,
  output logic [DATA_W-1:0]    ex_result,
  output logic                 ex_rf_we_o,
  output logic [4:0]           ex_rf_waddr_o,
  output logic [31:0]          ex_pc_o,
  output logic                 ex_res_from_mem_o,
  output logic [1:0]           ex_mem_size_o,
  output logic                 ex_ale,
  output logic [DATA_W+7:0]    ex_fwd,
  output logic                 data_sram_en,
  output logic [DATA_W/8-1:0]  data_sram_we,
  output logic [DATA_W-1:0]    data_sram_addr,
  output logic [DATA_W-1:0]    data_sram_wdata
);
  localparam int NB = DATA_W / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  typedef struct packed {
    logic [11:0]       alu_op;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic [2:0]        div_op;
    logic              mem_re;
    logic              mem_wr;
    logic [1:0]        mem_size;
    logic [DATA_W-1:0] st_data;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [31:0]       pc;
  } ex_pl_t;

  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_e;

  ex_pl_t            ex_pl_q, ex_pl_d;
  logic              ex_valid_q, ex_valid_d;
  div_state_e        div_state_q, div_state_d;
  logic [CNT_W-1:0]  div_cnt_q, div_cnt_d;
  // dvd_q starts as |dividend| and shifts quotient bits in from the right,
  // so after the last step it holds the quotient magnitude.
  logic [DATA_W-1:0] dvd_q, dvd_d;
  logic [DATA_W-1:0] dsr_q, dsr_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic              q_neg_q, q_neg_d, r_neg_q, r_neg_d, dz_q, dz_d;

  logic [DATA_W-1:0] alu_result;
  logic              div_en, want_rem, is_signed;
  logic              ex_ready_go, is_mem;
  logic [DATA_W:0]   rem_sh;
  logic              div_ge;
  logic [DATA_W-1:0] rem_sub, quo_res, rem_res;
  logic [BW-1:0]     byte_off;

  alu #(.DATA_W(DATA_W)) u_alu (
    .alu_op    (ex_pl_q.alu_op),
    .alu_src1  (ex_pl_q.src1),
    .alu_src2  (ex_pl_q.src2),
    .alu_result(alu_result)
  );

  assign div_en          = ex_pl_q.div_op[2];
  assign want_rem        = ex_pl_q.div_op[1];
  assign is_signed       = ex_pl_q.div_op[0];
  assign is_mem          = ex_pl_q.mem_re | ex_pl_q.mem_wr;
  assign ex_ready_go     = ~div_en | (div_state_q == DIV_DONE);
  assign ex_allowin      = ~ex_valid_q | (ex_ready_go & mem_allowin);
  assign ex_to_mem_valid = ex_valid_q & ex_ready_go & ~flush;

  // Pipeline register: capture a new instruction unless flushed
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_pl_d    = ex_pl_q;
    if (flush)           ex_valid_d = 1'b0;
    else if (ex_allowin) ex_valid_d = id_to_ex_valid;
    if (id_to_ex_valid & ex_allowin & ~flush) begin
      ex_pl_d.alu_op   = id_alu_op;
      ex_pl_d.src1     = id_src1;
      ex_pl_d.src2     = id_src2;
      ex_pl_d.div_op   = id_div_op;
      ex_pl_d.mem_re   = id_mem_re;
      ex_pl_d.mem_wr   = id_mem_wr;
      ex_pl_d.mem_size = id_mem_size;
      ex_pl_d.st_data  = id_st_data;
      ex_pl_d.rf_we    = id_rf_we;
      ex_pl_d.rf_waddr = id_rf_waddr;
      ex_pl_d.pc       = id_pc;
    end
  end

  // Divider FSM next-state and one restoring shift-subtract step per BUSY cycle
  always_comb begin
    rem_sh      = {rem_q, dvd_q[DATA_W-1]};
    // A set top bit means the shifted remainder exceeds any W-bit divisor,
    // and the true difference then still fits in W bits.
    div_ge      = rem_sh[DATA_W] | (rem_sh[DATA_W-1:0] >= dsr_q);
    rem_sub     = rem_sh[DATA_W-1:0] - dsr_q;
    div_state_d = div_state_q;
    div_cnt_d   = div_cnt_q;
    dvd_d       = dvd_q;
    dsr_d       = dsr_q;
    rem_d       = rem_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    dz_d        = dz_q;
    case (div_state_q)
      DIV_IDLE: begin
        if (ex_valid_q & div_en) begin
          div_state_d = DIV_BUSY;
          dvd_d     = (is_signed & ex_pl_q.src1[DATA_W-1]) ? -ex_pl_q.src1 : ex_pl_q.src1;
          dsr_d     = (is_signed & ex_pl_q.src2[DATA_W-1]) ? -ex_pl_q.src2 : ex_pl_q.src2;
          q_neg_d   = is_signed & (ex_pl_q.src1[DATA_W-1] ^ ex_pl_q.src2[DATA_W-1]);
          r_neg_d   = is_signed & ex_pl_q.src1[DATA_W-1];
          dz_d      = (ex_pl_q.src2 == '0);
          rem_d     = '0;
          div_cnt_d = CNT_W'(DATA_W);
        end
      end
      DIV_BUSY: begin
        rem_d     = div_ge ? rem_sub : rem_sh[DATA_W-1:0];
        dvd_d     = {dvd_q[DATA_W-2:0], div_ge};
        div_cnt_d = div_cnt_q - CNT_W'(1);
        if (div_cnt_q == CNT_W'(1)) div_state_d = DIV_DONE;
      end
      DIV_DONE: begin
        if (ex_to_mem_valid & mem_allowin) div_state_d = DIV_IDLE;
      end
      default: div_state_d = DIV_IDLE;
    endcase
    if (flush) div_state_d = DIV_IDLE;
  end

  // Sign fix-up of the held magnitudes; divide-by-zero forces an all-ones
  // quotient, while its remainder naturally equals the dividend.
  always_comb begin
    quo_res   = dz_q ? '1 : (q_neg_q ? -dvd_q : dvd_q);
    rem_res   = r_neg_q ? -rem_q : rem_q;
    ex_result = div_en ? (want_rem ? rem_res : quo_res) : alu_result;
  end

  assign byte_off = (NB > 1) ? alu_result[BW-1:0] : '0;

  // Memory request: alignment check, byte enables and lane-replicated data
  always_comb begin
    ex_ale = is_mem & (((ex_pl_q.mem_size == 2'd1) & alu_result[0]) |
                       (ex_pl_q.mem_size[1] & (alu_result[1:0] != 2'b00)));
    data_sram_en    = ex_valid_q & is_mem & ~ex_ale & ~flush;
    data_sram_addr  = alu_result;
    data_sram_we    = '0;
    data_sram_wdata = ex_pl_q.st_data;
    for (int i = 0; i < NB; i++) begin
      case (ex_pl_q.mem_size)
        2'd0: begin
          data_sram_wdata[8*i +: 8] = ex_pl_q.st_data[7:0];
          if (ex_pl_q.mem_wr & data_sram_en) data_sram_we[i] = (BW'(i) == byte_off);
        end
        2'd1: begin
          data_sram_wdata[8*i +: 8] = ex_pl_q.st_data[8*(i%2) +: 8];
          if (ex_pl_q.mem_wr & data_sram_en) data_sram_we[i] = ((BW'(i) >> 1) == (byte_off >> 1));
        end
        default: begin
          if (ex_pl_q.mem_wr & data_sram_en) data_sram_we[i] = 1'b1;
        end
      endcase
    end
  end

  assign ex_rf_we_o        = ex_pl_q.rf_we;
  assign ex_rf_waddr_o     = ex_pl_q.rf_waddr;
  assign ex_pc_o           = ex_pl_q.pc;
  assign ex_res_from_mem_o = ex_pl_q.mem_re;
  assign ex_mem_size_o     = ex_pl_q.mem_size;
  assign ex_fwd = ex_valid_q ? {ex_pl_q.mem_re, div_en & (div_state_q != DIV_DONE),
                                ex_pl_q.rf_we, ex_pl_q.rf_waddr, ex_result} : '0;

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q  <= 1'b0;
      ex_pl_q     <= '0;
      div_state_q <= DIV_IDLE;
      div_cnt_q   <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      rem_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_pl_q     <= ex_pl_d;
      div_state_q <= div_state_d;
      div_cnt_q   <= div_cnt_d;
      dvd_q       <= dvd_d;
      dsr_q       <= dsr_d;
      rem_q       <= rem_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      dz_q        <= dz_d;
    end
  end
endmodule
